// File: rtl/reg_file_pkg.sv
// Shared widths, depth helper and packed-bus slicing helpers
// for the multi-port register file.
package reg_file_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_READ   = 2;
  localparam int RF_NUM_WRITE  = 1;
  localparam int RF_CAP        = 1 << RF_ADDR_WIDTH;

  function automatic int rf_cap(input int aw);
    return 1 << aw;
  endfunction

  // Low bit of port idx inside a packed bus of w-bit fields.
  function automatic int rf_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: address mux, write-first bypass
// across all write ports, and the r_data/r_valid registers.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_WRITE  = RF_NUM_WRITE,
  parameter int CAP        = rf_cap(ADDR_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_mem   [CAP],
  input  logic [NUM_WRITE-1:0]  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr [NUM_WRITE],
  input  logic [DATA_WIDTH-1:0] i_wdata [NUM_WRITE],
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // Ascending scan: the highest matching write port wins.
  always_comb begin
    w_rd = i_mem[i_addr];
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (i_wen[j] && (i_waddr[j] == i_addr)) begin
        w_rd = i_wdata[j];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_data <= w_rd;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file, registered reads, write-first bypass.
// Define ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_READ   = RF_NUM_READ,
  parameter int NUM_WRITE  = RF_NUM_WRITE
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_READ-1:0]            r_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] r_data,
  output logic [NUM_READ-1:0]            r_valid,
  input  logic [NUM_WRITE-1:0]           w_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] w_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] w_data
);

  localparam int CAP = rf_cap(ADDR_WIDTH);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0] w_waddr [NUM_WRITE];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_WRITE];
  logic [NUM_WRITE-1:0]  w_wen;
  logic [DATA_WIDTH-1:0] w_mem   [CAP];

  // Writes to a hardwired zero register vanish before collision and bypass.
  for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr
    assign w_waddr[j] = w_addr[rf_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
    assign w_wdata[j] = w_data[rf_lo(j, DATA_WIDTH) +: DATA_WIDTH];
    assign w_wen[j]   = w_en[j] & ~(ZERO_REG & ~(|w_waddr[j]));
  end

  for (genvar k = 0; k < CAP; k++) begin : g_ent
    if (ZERO_REG && (k == 0)) begin : g_zero
      assign w_mem[k] = '0;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_q <= '0;
        end else begin
          for (int j = 0; j < NUM_WRITE; j++) begin
            if (w_wen[j] && (w_waddr[j] == ADDR_WIDTH'(k))) begin
              r_q <= w_wdata[j];
            end
          end
        end
      end

      assign w_mem[k] = r_q;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    reg_file_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WRITE  (NUM_WRITE),
      .CAP        (CAP)
    ) u_rp (
      .clock   (clock),
      .reset_n (reset_n),
      .i_en    (r_en[i]),
      .i_addr  (r_addr[rf_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]),
      .i_mem   (w_mem),
      .i_wen   (w_wen),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .o_data  (r_data[rf_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .o_valid (r_valid[i])
    );
  end

endmodule
